// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises 32-bit MEM-stage loads/stores and IF word fetches onto a
// byte-wide synchronous RAM with 1-cycle read latency. MEM stage has priority.
//   clk, rst                         : clock, async active-high reset
//   mem_re/mem_we/mem_sel/mem_addr/
//   mem_wdata                        : MEM-stage request (held until mem_done)
//   mem_busy/mem_done/mem_rdata      : MEM-stage status, done pulse, load data
//   if_re/if_addr                    : fetch request (held until if_done)
//   if_busy/if_done/if_data          : fetch status, done pulse, fetched word
//   ram_addr/ram_wr/ram_dout/ram_din : byte RAM port
module mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_re,
  input  logic                  mem_we,
  input  logic [3:0]            mem_sel,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_busy,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  input  logic                  if_re,
  input  logic [31:0]           if_addr,
  output logic                  if_busy,
  output logic                  if_done,
  output logic [31:0]           if_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din
);

  localparam int unsigned LINE_W = ADDR_WIDTH - 2;
  localparam int unsigned BEAT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  localparam logic OWN_DATA  = 1'b0;
  localparam logic OWN_FETCH = 1'b1;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [LINE_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          sel_q, sel_d;
  logic [23:0]         rbuf_q, rbuf_d;
  logic                mem_done_q, mem_done_d;
  logic                if_done_q, if_done_d;
  logic [31:0]         mem_rdata_q, mem_rdata_d;
  logic [31:0]         if_data_q, if_data_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                ram_wr_q, ram_wr_d;
  logic [7:0]          ram_dout_q, ram_dout_d;
  logic [1:0]          nbeat;

  // Address bits outside the RAM word index are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH], mem_addr[1:0],
                              if_addr[31:ADDR_WIDTH], if_addr[1:0]};

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_DATA;
      beat_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      rbuf_q      <= '0;
      mem_done_q  <= 1'b0;
      if_done_q   <= 1'b0;
      mem_rdata_q <= '0;
      if_data_q   <= '0;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      beat_q      <= beat_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      rbuf_q      <= rbuf_d;
      mem_done_q  <= mem_done_d;
      if_done_q   <= if_done_d;
      mem_rdata_q <= mem_rdata_d;
      if_data_q   <= if_data_d;
      ram_addr_q  <= ram_addr_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
    end
  end

  // Next state; RAM-side outputs are computed one beat ahead so they are
  // registered yet line up with the beat they belong to.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    beat_d      = beat_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    rbuf_d      = rbuf_q;
    mem_done_d  = 1'b0;
    if_done_d   = 1'b0;
    mem_rdata_d = mem_rdata_q;
    if_data_d   = if_data_q;
    ram_addr_d  = ram_addr_q;
    ram_wr_d    = 1'b0;
    ram_dout_d  = ram_dout_q;
    nbeat       = beat_q[1:0] + 2'd1;

    unique case (state_q)
      S_IDLE: begin
        if (mem_we || mem_re || if_re) begin
          beat_d  = '0;
          wdata_d = mem_wdata;
          sel_d   = mem_sel;
          if (mem_we || mem_re) begin
            owner_d = OWN_DATA;
            addr_d  = mem_addr[ADDR_WIDTH-1:2];
          end else begin
            owner_d = OWN_FETCH;
            addr_d  = if_addr[ADDR_WIDTH-1:2];
          end
          ram_addr_d = {addr_d, 2'b00};
          if (mem_we) begin
            state_d    = S_WR;
            ram_dout_d = mem_wdata[7:0];
            ram_wr_d   = mem_sel[0];
          end else begin
            state_d = S_RD;
          end
        end
      end

      S_RD: begin
        // ram_din carries the byte addressed in the previous beat.
        case (beat_q)
          3'd1:    rbuf_d[7:0]   = ram_din;
          3'd2:    rbuf_d[15:8]  = ram_din;
          3'd3:    rbuf_d[23:16] = ram_din;
          default: ;
        endcase
        if (beat_q == 3'd4) begin
          state_d = S_DONE;
          if (owner_q == OWN_DATA) begin
            mem_done_d  = 1'b1;
            mem_rdata_d = {ram_din, rbuf_q};
          end else begin
            if_done_d = 1'b1;
            if_data_d = {ram_din, rbuf_q};
          end
        end else begin
          beat_d = beat_q + 3'd1;
          if (beat_q < 3'd3) ram_addr_d = {addr_q, nbeat};
        end
      end

      S_WR: begin
        if (beat_q[1:0] == 2'd3) begin
          state_d    = S_DONE;
          mem_done_d = 1'b1;
        end else begin
          beat_d     = {1'b0, nbeat};
          ram_addr_d = {addr_q, nbeat};
          ram_dout_d = 8'(wdata_q >> {nbeat, 3'b000});
          ram_wr_d   = sel_q[nbeat];
        end
      end

      S_DONE: state_d = S_IDLE;
    endcase
  end

  assign mem_busy  = (state_q == S_RD) || (state_q == S_WR);
  assign if_busy   = mem_busy;
  assign mem_done  = mem_done_q;
  assign if_done   = if_done_q;
  assign mem_rdata = mem_rdata_q;
  assign if_data   = if_data_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wr    = ram_wr_q;
  assign ram_dout  = ram_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: byte RAM model, directed requests, scoreboard of
// expected done pulses checked by an independent monitor.
module tb_mem_ctrl;

  localparam int unsigned AW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_re, mem_we;
  logic [3:0]    mem_sel;
  logic [31:0]   mem_addr, mem_wdata;
  logic          mem_busy, mem_done;
  logic [31:0]   mem_rdata;
  logic          if_re;
  logic [31:0]   if_addr;
  logic          if_busy, if_done;
  logic [31:0]   if_data;
  logic [AW-1:0] ram_addr;
  logic          ram_wr;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din;

  mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .mem_re(mem_re), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_busy(mem_busy), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .if_re(if_re), .if_addr(if_addr), .if_busy(if_busy),
    .if_done(if_done), .if_data(if_data), .ram_addr(ram_addr), .ram_wr(ram_wr),
    .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // Byte RAM, 1-cycle read latency.
  logic [7:0] ram [0:(1<<AW)-1];
  int wr_count = 0;
  always @(posedge clk) begin
    if (ram_wr) begin
      ram[ram_addr] <= ram_dout;
      wr_count++;
    end
    ram_din <= ram[ram_addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic        fetch;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];
  int done_cnt = 0;

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!rst && (mem_done || if_done)) begin
      exp_t e;
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(1), 32'(0));
      end else begin
        e = sb_q.pop_front();
        check("done_kind", 32'({mem_done, if_done}), e.fetch ? 32'd1 : 32'd2);
        check(e.fetch ? "if_data" : "mem_rdata", e.fetch ? if_data : mem_rdata, e.data);
      end
    end
  end

  logic [AW-1:0] addr_tr [0:19];
  logic          wr_tr   [0:19];
  logic [7:0]    dout_tr [0:19];
  logic          if_chg;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic re, input logic fr,
                       input logic [31:0] a, input logic [31:0] fa,
                       input logic [3:0] s, input logic [31:0] wd);
    mem_we = we; mem_re = re; if_re = fr;
    mem_addr = a; if_addr = fa; mem_sel = s; mem_wdata = wd;
  endtask

  task automatic drop_all();
    mem_we = 1'b0; mem_re = 1'b0; if_re = 1'b0;
  endtask

  // Counts cycles from the request-sampling cycle to the cycle showing done.
  task automatic wait_done(output int lat, output int bsy);
    logic [31:0] if0;
    if0 = if_data;
    if_chg = 1'b0;
    lat = 0;
    bsy = 0;
    do begin
      tick();
      lat++;
      addr_tr[lat-1] = ram_addr;
      wr_tr[lat-1]   = ram_wr;
      dout_tr[lat-1] = ram_dout;
      if (mem_busy) bsy++;
      if (if_data != if0) if_chg = 1'b1;
    end while (!(mem_done || if_done) && lat < 20);
  endtask

  initial begin
    int lat, bsy, wc0, dc0;
    logic [31:0] exp_rdata;

    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
    ram[17'h100] = 8'h11; ram[17'h101] = 8'h22; ram[17'h102] = 8'h33; ram[17'h103] = 8'h44;
    ram[17'h200] = 8'h01; ram[17'h201] = 8'h02; ram[17'h202] = 8'h03; ram[17'h203] = 8'h04;
    ram[17'h300] = 8'hA0; ram[17'h301] = 8'hA1; ram[17'h302] = 8'hA2; ram[17'h303] = 8'hA3;
    ram[17'h010] = 8'h5A; ram[17'h011] = 8'h6B; ram[17'h012] = 8'h7C; ram[17'h013] = 8'h8D;
    ram[17'h040] = 8'hDE; ram[17'h041] = 8'hAD; ram[17'h042] = 8'hBE; ram[17'h043] = 8'hEF;

    rst = 1'b1;
    drop_all();
    mem_sel = 4'h0; mem_addr = '0; mem_wdata = '0; if_addr = '0;
    exp_rdata = 32'h0;
    repeat (2) tick();

    check("rst_busy",  32'({mem_busy, if_busy}), 32'd0);
    check("rst_done",  32'({mem_done, if_done}), 32'd0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_ifdata", if_data, 32'h0);
    check("rst_ram", 32'({ram_addr, ram_wr, ram_dout}), 32'd0);
    rst = 1'b0;
    tick();

    // Reset in the middle of a full-word store.
    issue(1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 4'hF, 32'h99887766);
    tick();
    tick();
    check("midwr_wr_before", 32'(ram_wr), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midwr_wr_drop", 32'(ram_wr), 32'd0);
    drop_all();
    tick();
    rst = 1'b0;
    wc0 = wr_count;
    repeat (4) tick();
    check("midwr_busy", 32'(mem_busy), 32'd0);
    check("midwr_no_wr", 32'(wr_count - wc0), 32'd0);
    check("midwr_byte0", 32'(ram[17'h400]), 32'h66);
    check("midwr_byte23", {16'h0, ram[17'h402], ram[17'h403]}, 32'h0);

    // Word load from a misaligned address.
    exp_rdata = 32'h44332211;
    sb_q.push_back('{fetch: 1'b0, data: exp_rdata});
    issue(1'b0, 1'b1, 1'b0, 32'h102, 32'h0, 4'h0, 32'h0);
    wait_done(lat, bsy);
    check("ld_lat", 32'(lat), 32'd6);
    check("ld_busy", 32'(bsy), 32'd5);
    for (int k = 0; k < 4; k++) check("ld_addr", 32'(addr_tr[k]), 32'h100 + 32'(k));
    drop_all();
    tick();

    // Store byte 1.
    wc0 = wr_count;
    sb_q.push_back('{fetch: 1'b0, data: exp_rdata});
    issue(1'b1, 1'b0, 1'b0, 32'h201, 32'h0, 4'b0010, 32'hABABABAB);
    wait_done(lat, bsy);
    check("sb_lat", 32'(lat), 32'd5);
    check("sb_busy", 32'(bsy), 32'd4);
    check("sb_wr_beats", 32'({wr_tr[3], wr_tr[2], wr_tr[1], wr_tr[0]}), 32'b0010);
    check("sb_addr", 32'(addr_tr[1]), 32'h201);
    check("sb_dout", 32'(dout_tr[1]), 32'hAB);
    check("sb_wr_count", 32'(wr_count - wc0), 32'd1);
    drop_all();
    tick();

    exp_rdata = 32'h0403AB01;
    sb_q.push_back('{fetch: 1'b0, data: exp_rdata});
    issue(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 32'h0);
    wait_done(lat, bsy);
    check("sb_rb_lat", 32'(lat), 32'd6);
    drop_all();
    tick();

    // Store with no lanes enabled.
    wc0 = wr_count;
    sb_q.push_back('{fetch: 1'b0, data: exp_rdata});
    issue(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 4'b0000, 32'hFFFFFFFF);
    wait_done(lat, bsy);
    check("s0_lat", 32'(lat), 32'd5);
    check("s0_busy", 32'(bsy), 32'd4);
    check("s0_wr_beats", 32'({wr_tr[3], wr_tr[2], wr_tr[1], wr_tr[0]}), 32'b0000);
    check("s0_wr_count", 32'(wr_count - wc0), 32'd0);
    drop_all();
    tick();

    exp_rdata = 32'hA3A2A1A0;
    sb_q.push_back('{fetch: 1'b0, data: exp_rdata});
    issue(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 32'h0);
    wait_done(lat, bsy);
    check("s0_rb_lat", 32'(lat), 32'd6);
    drop_all();
    tick();

    // Simultaneous load and fetch: data first, fetch held and served next.
    exp_rdata = 32'h8D7C6B5A;
    sb_q.push_back('{fetch: 1'b0, data: exp_rdata});
    sb_q.push_back('{fetch: 1'b1, data: 32'hEFBEADDE});
    issue(1'b0, 1'b1, 1'b1, 32'h10, 32'h40, 4'h0, 32'h0);
    wait_done(lat, bsy);
    check("sim_data_lat", 32'(lat), 32'd6);
    check("sim_data_first", 32'({mem_done, if_done}), 32'b10);
    check("sim_ifdata_hold", 32'(if_chg), 32'd0);
    mem_re = 1'b0;
    wait_done(lat, bsy);
    check("sim_fetch_lat", 32'(lat), 32'd7);
    check("sim_fetch_busy", 32'(bsy), 32'd5);
    check("sim_rdata_hold", mem_rdata, exp_rdata);
    drop_all();
    tick();

    // Request held through DONE: one done per acceptance.
    exp_rdata = 32'h44332211;
    sb_q.push_back('{fetch: 1'b0, data: exp_rdata});
    sb_q.push_back('{fetch: 1'b0, data: exp_rdata});
    dc0 = done_cnt;
    issue(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 32'h0);
    wait_done(lat, bsy);
    check("hold_lat1", 32'(lat), 32'd6);
    tick();
    check("hold_idle", 32'({mem_busy, mem_done}), 32'd0);
    wait_done(lat, bsy);
    check("hold_lat2", 32'(lat), 32'd6);
    check("hold_busy2", 32'(bsy), 32'd5);
    drop_all();
    repeat (8) tick();
    check("hold_done_count", 32'(done_cnt - dc0), 32'd2);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller directly downstream of the MEM stage and of instruction fetch.
- Accepts 32-bit word load/store requests from the MEM stage (mem_re/mem_we/mem_sel/mem_addr) and word fetches from IF.
- Serialises each request onto a byte-wide synchronous RAM with 1-cycle read latency.
- Returns mem_busy/mem_done and assembled read data. The MEM stage takes priority over fetch.

Parameters:
- ADDR_WIDTH, 17, width of ram_addr; ram_addr = {latched_addr[ADDR_WIDTH-1:2], beat[1:0]}

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_re  in  1  MEM-stage load request (held until mem_done)
- mem_we  in  1  MEM-stage store request (held until mem_done)
- mem_sel  in  4  store byte-lane enables; ignored for loads
- mem_addr  in  32  MEM-stage byte address
- mem_wdata  in  32  store data, lane k = bits [8k+7:8k]
- mem_busy  out  1  controller occupied with any access (RD/WR state)
- mem_done  out  1  one-cycle pulse: MEM-stage access complete
- mem_rdata  out  32  loaded word, valid with mem_done, held until next data read completes
- if_re  in  1  fetch request (held until if_done)
- if_addr  in  32  fetch address (bits [1:0] ignored)
- if_busy  out  1  same as mem_busy
- if_done  out  1  one-cycle pulse: fetch complete
- if_data  out  32  fetched word, valid with if_done, held until next fetch completes
- ram_addr  out  ADDR_WIDTH  RAM byte address
- ram_wr  out  1  RAM write strobe for current beat
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte, valid the cycle after its address is driven

Behaviour:
- Reset (async, any state):
  - state=IDLE, owner=0, beat=0.
  - All outputs 0: mem_busy, mem_done, mem_rdata, if_busy, if_done, if_data, ram_addr, ram_wr, ram_dout.
  - An in-flight access is abandoned. No write completes after reset asserts.
- States: IDLE, RD, WR, DONE. All outputs registered except busy = (state==RD || state==WR).
- IDLE acceptance on a rising edge:
  - Priority: mem_we, then mem_re, then if_re. mem_re and mem_we both high is treated as a store.
  - Latch at acceptance: addr {addr[31:2],2'b00}, wdata, sel, owner (DATA/FETCH). Clear beat.
  - Go to RD (load/fetch) or WR (store).
  - Requests arriving outside IDLE are ignored; requesters hold them.
- RD, beats 0..4:
  - Beats 0..3 drive ram_addr for byte = beat.
  - Beats 1..4 capture ram_din into byte lane beat-1, little-endian (byte at offset 0 lands in [7:0]).
  - After beat 4, go to DONE.
  - Latency: acceptance edge + 5 RD cycles, then 1 DONE cycle. done is visible 6 cycles after the cycle in which the request was sampled.
- WR, beats 0..3:
  - ram_addr = lane beat; ram_dout = wdata lane beat; ram_wr = sel[beat].
  - Fixed 4 beats regardless of sel; sel=0000 is a legal no-op taking the same time.
  - After beat 3, go to DONE. mem_rdata is unchanged.
- DONE, exactly one cycle:
  - busy=0.
  - mem_done=1 if owner=DATA, else if_done=1. Only the owner's data output updates.
  - Go to IDLE unconditionally. No request is accepted in DONE, so a requester dropping its request after done is never re-served.
- Outside WR, ram_wr=0. ram_addr holds its last value when idle.
- Fetch starvation is acceptable: back-to-back MEM requests may delay fetch indefinitely.
- A store to a misaligned halfword/word arrives with sel=0000 and writes nothing.

Test Plan:
- Reset mid-WR at beat 1 with sel=1111:
  - ram_wr drops the same cycle rst rises.
  - After release, busy=0 and no further ram_wr.
  - Bytes 2..3 remain unwritten.
- Load: RAM bytes 0x100..0x103 = 11,22,33,44, mem_re with mem_addr=0x102:
  - ram_addr 0x100..0x103 on consecutive cycles.
  - mem_done one cycle later with mem_rdata=0x44332211, 6 cycles after the request.
  - mem_busy high 5 cycles.
- Store SB: mem_addr=0x201, mem_sel=0010, mem_wdata=0xABABABAB:
  - ram_wr only on beat 1 at 0x201 with 0xAB.
  - Readback word at 0x200 shows only byte 1 changed.
- Simultaneous mem_re (0x10) and if_re (0x40) in IDLE:
  - Data served first, with mem_done only.
  - The held fetch is accepted in the IDLE cycle after DONE; if_done follows 6 cycles later with the correct word.
  - if_data is unchanged during the data access.
- Store with sel=0000:
  - 4 WR beats with ram_wr never high.
  - mem_done pulses once.
  - RAM unchanged.
- Request held high through DONE:
  - Exactly one mem_done per acceptance.
  - A new acceptance occurs only in the following IDLE cycle.
